// File: rtl/iagc_pkg.sv
// iagc_pkg: shared definitions for the Zmod Scope gain controller.
// Holds the status/state codes, the sample field positions inside the
// 32-bit ADC stream word, the magnitude type and the saturating abs helper.
package iagc_pkg;

    // Status codes; the FSM state encoding is the status code itself.
    localparam logic [3:0] IAGC_STATUS_RESET     = 4'b0000;
    localparam logic [3:0] IAGC_STATUS_WAIT_INIT = 4'b0001;
    localparam logic [3:0] IAGC_STATUS_MEASURE   = 4'b0010;
    localparam logic [3:0] IAGC_STATUS_DECIDE    = 4'b0011;
    localparam logic [3:0] IAGC_STATUS_SETTLE    = 4'b0100;

    typedef enum logic [3:0] {
        ST_IDLE      = IAGC_STATUS_RESET,
        ST_WAIT_INIT = IAGC_STATUS_WAIT_INIT,
        ST_MEASURE   = IAGC_STATUS_MEASURE,
        ST_DECIDE    = IAGC_STATUS_DECIDE,
        ST_SETTLE    = IAGC_STATUS_SETTLE
    } iagc_state_t;

    // Channel sample positions inside the ADC stream word.
    localparam int CH1_MSB = 31;
    localparam int CH1_LSB = 18;
    localparam int CH2_MSB = 15;
    localparam int CH2_LSB = 2;

    // Peak magnitudes are 13 bits unsigned; |-8192| is clipped to 8191.
    localparam int MAG_WIDTH = 13;
    typedef logic [MAG_WIDTH-1:0] iagc_mag_t;
    localparam iagc_mag_t MAG_MAX = '1;

    // Saturating absolute value of a 14-bit two's complement sample.
    // For any negative value other than -8192 the true magnitude fits in
    // 13 bits, so negating only the low 13 bits gives the exact result.
    function automatic iagc_mag_t sat_abs(input logic [13:0] x);
        if (x == 14'h2000) begin
            return MAG_MAX;
        end
        if (x[13]) begin
            return ~x[12:0] + 13'd1;
        end
        return x[12:0];
    endfunction

endpackage

// File: rtl/iagc_peak_detector.sv
// iagc_peak_detector: running peak of |sample| for one channel.
// The peak register is cleared while i_clear is high and otherwise grows
// to the largest saturated magnitude seen on strobed samples.
module iagc_peak_detector
    import iagc_pkg::*;
(
    input  logic        i_sys_clock,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_strobe,
    input  logic [13:0] i_sample,
    output logic [12:0] o_peak
);

    logic [12:0] w_mag;
    logic [12:0] r_peak;

    assign w_mag  = sat_abs(i_sample);
    assign o_peak = r_peak;

    // Track the largest magnitude seen since the last clear.
    always_ff @(posedge i_sys_clock) begin
        if (!i_reset_n) begin
            r_peak <= '0;
        end else if (i_clear) begin
            r_peak <= '0;
        end else if (i_strobe && (w_mag > r_peak)) begin
            r_peak <= w_mag;
        end
    end

endmodule

// File: rtl/iagc_controller.sv
// iagc_controller: closed-loop gain relay controller for the Zmod Scope.
// Measures per-channel peak magnitude over fixed sample windows, switches
// each channel's gain relay with hysteresis and waits for relays to settle.
// Optional feature macro: IAGC_OVERRIDE_EN adds manual gain override ports.
module iagc_controller
    import iagc_pkg::*;
#(
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int AXIS_DATA_SIZE   = 32,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int WINDOW_SAMPLES   = 1024,
    parameter int SETTLE_CYCLES    = 100000,
    parameter int HIGH_THRESHOLD   = 7800,
    parameter int LOW_THRESHOLD    = 300
) (
    input  logic                        i_sys_clock,
    input  logic                        i_reset_n,
    input  logic                        i_enable,
    input  logic                        i_init_done,
    input  logic [AXIS_DATA_SIZE-1:0]   i_adc_data,
    input  logic                        i_adc_data_valid,
`ifdef IAGC_OVERRIDE_EN
    input  logic                        i_override,
    input  logic                        i_override_ch1_gain,
    input  logic                        i_override_ch2_gain,
`endif
    output logic                        o_adc_data_ready,
    output logic                        o_ch1_gain,
    output logic                        o_ch2_gain,
    output logic                        o_gain_update,
    output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status
);

    localparam int WIN_W    = $clog2(WINDOW_SAMPLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [WIN_W-1:0]    WIN_LAST    = WIN_W'(WINDOW_SAMPLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    localparam iagc_mag_t HIGH_T = iagc_mag_t'(HIGH_THRESHOLD);
    localparam iagc_mag_t LOW_T  = iagc_mag_t'(LOW_THRESHOLD);

    iagc_state_t         r_state;
    logic                r_ch1_gain;
    logic                r_ch2_gain;
    logic                r_gain_update;
    logic                r_ready;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;

    logic [ZMOD_DATA_SIZE-1:0] w_ch1_sample;
    logic [ZMOD_DATA_SIZE-1:0] w_ch2_sample;
    logic [12:0]               w_ch1_peak;
    logic [12:0]               w_ch2_peak;
    logic                      w_accept;
    logic                      w_last_sample;
    logic                      w_peak_clear;
    logic                      w_ch1_next;
    logic                      w_ch2_next;
    logic                      w_gain_change;
    logic                      w_unused_bits;

    assign w_ch1_sample  = i_adc_data[CH1_MSB:CH1_LSB];
    assign w_ch2_sample  = i_adc_data[CH2_MSB:CH2_LSB];
    assign w_unused_bits = ^{i_adc_data[CH1_LSB-1:CH2_MSB+1], i_adc_data[CH2_LSB-1:0]};

    // Only samples taken while measuring contribute to the peaks; samples
    // arriving in DECIDE, SETTLE or WAIT_INIT are accepted and dropped.
    assign w_accept      = (r_state == ST_MEASURE) && i_adc_data_valid && r_ready;
    assign w_last_sample = w_accept && (r_win_cnt == WIN_LAST);

    // Peaks stay cleared outside MEASURE, so every window starts from zero.
    // The DECIDE cycle still reads the old peak because the clear only
    // lands on the edge that leaves DECIDE.
    assign w_peak_clear = (r_state != ST_MEASURE);

    iagc_peak_detector u_peak_ch1 (
        .i_sys_clock (i_sys_clock),
        .i_reset_n   (i_reset_n),
        .i_clear     (w_peak_clear),
        .i_strobe    (w_accept),
        .i_sample    (w_ch1_sample),
        .o_peak      (w_ch1_peak)
    );

    iagc_peak_detector u_peak_ch2 (
        .i_sys_clock (i_sys_clock),
        .i_reset_n   (i_reset_n),
        .i_clear     (w_peak_clear),
        .i_strobe    (w_accept),
        .i_sample    (w_ch2_sample),
        .o_peak      (w_ch2_peak)
    );

`ifdef IAGC_OVERRIDE_EN
    logic w_ovr_active;
    logic w_ovr_change;

    assign w_ovr_active = i_override && (r_state != ST_IDLE);
    assign w_ovr_change = w_ovr_active &&
                          ((i_override_ch1_gain != r_ch1_gain) ||
                           (i_override_ch2_gain != r_ch2_gain));
`endif

    // Hysteresis decision per channel: leave high gain only above the high
    // threshold, leave low gain only below the low threshold.
    always_comb begin
        w_ch1_next = r_ch1_gain;
        w_ch2_next = r_ch2_gain;
`ifdef IAGC_OVERRIDE_EN
        if (!w_ovr_active) begin
`else
        begin
`endif
            if (r_ch1_gain && (w_ch1_peak > HIGH_T)) begin
                w_ch1_next = 1'b0;
            end else if (!r_ch1_gain && (w_ch1_peak < LOW_T)) begin
                w_ch1_next = 1'b1;
            end
            if (r_ch2_gain && (w_ch2_peak > HIGH_T)) begin
                w_ch2_next = 1'b0;
            end else if (!r_ch2_gain && (w_ch2_peak < LOW_T)) begin
                w_ch2_next = 1'b1;
            end
        end
    end

    assign w_gain_change = (w_ch1_next != r_ch1_gain) || (w_ch2_next != r_ch2_gain);

    // Main controller FSM with registered status, gains, update pulse and ready.
    always_ff @(posedge i_sys_clock) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_ch1_gain    <= 1'b0;
            r_ch2_gain    <= 1'b0;
            r_gain_update <= 1'b0;
            r_ready       <= 1'b0;
            r_win_cnt     <= '0;
            r_settle_cnt  <= '0;
        end else if (!i_enable) begin
            r_state       <= ST_IDLE;
            r_ch1_gain    <= 1'b0;
            r_ch2_gain    <= 1'b0;
            r_gain_update <= 1'b0;
            r_ready       <= 1'b0;
            r_win_cnt     <= '0;
            r_settle_cnt  <= '0;
        end else begin
            r_gain_update <= 1'b0;
            r_ready       <= 1'b1;
            if (r_state != ST_MEASURE) begin
                r_win_cnt <= '0;
            end
`ifdef IAGC_OVERRIDE_EN
            if (w_ovr_change) begin
                r_ch1_gain    <= i_override_ch1_gain;
                r_ch2_gain    <= i_override_ch2_gain;
                r_gain_update <= 1'b1;
                r_settle_cnt  <= '0;
                r_state       <= ST_SETTLE;
            end else
`endif
            begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_WAIT_INIT;
                    end
                    ST_WAIT_INIT: begin
                        if (i_init_done) begin
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (!i_init_done) begin
                            r_state <= ST_WAIT_INIT;
                        end else if (w_last_sample) begin
                            r_state <= ST_DECIDE;
                        end else if (w_accept) begin
                            r_win_cnt <= r_win_cnt + WIN_W'(1);
                        end
                    end
                    ST_DECIDE: begin
                        if (!i_init_done) begin
                            r_state <= ST_WAIT_INIT;
                        end else if (w_gain_change) begin
                            r_ch1_gain    <= w_ch1_next;
                            r_ch2_gain    <= w_ch2_next;
                            r_gain_update <= 1'b1;
                            r_settle_cnt  <= '0;
                            r_state       <= ST_SETTLE;
                        end else begin
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_SETTLE: begin
                        if (!i_init_done) begin
                            r_state <= ST_WAIT_INIT;
                        end else if (r_settle_cnt == SETTLE_LAST) begin
                            r_state <= ST_MEASURE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_adc_data_ready = r_ready;
    assign o_ch1_gain       = r_ch1_gain;
    assign o_ch2_gain       = r_ch2_gain;
    assign o_gain_update    = r_gain_update;
    assign o_iagc_status    = IAGC_STATUS_SIZE'(r_state);

endmodule
